// File: rtl/dnpcie_aurora_wd_pkg.sv
// Shared types and widths for the Aurora link watchdog.
// Optional statistics are enabled by defining AURORA_WATCHDOG_STATS_EN.
package dnpcie_aurora_wd_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_W = 8;
    localparam int unsigned STAT_W  = 16;

    typedef enum logic [STATE_W-1:0] {
        StIdle     = 3'd0,
        StWaitUp   = 3'd1,
        StUp       = 3'd2,
        StReq      = 3'd3,
        StWaitDone = 3'd4,
        StFailed   = 3'd5
    } wd_state_e;

    function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dnpcie_aurora_wd_filter.sv
// 2-FF synchronizer with an optional consecutive-cycle level counter.
// LENGTH = 0 gives a plain synchronizer; hit_o is then tied low.
module dnpcie_aurora_wd_filter #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned LENGTH = 0,
    parameter bit          ACTIVE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] async_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] sync_o,
    output logic             hit_o
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_meta_q;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_meta_q <= '0;
            r_sync_q <= '0;
        end else begin
            r_meta_q <= async_i;
            r_sync_q <= r_meta_q;
        end
    end

    assign sync_o = r_sync_q;

    generate
        if (LENGTH == 0) begin : g_raw
            logic w_unused_clear;
            assign w_unused_clear = clear_i;
            assign hit_o          = 1'b0;
        end else begin : g_count
            localparam int unsigned CW = $clog2(LENGTH + 1);

            logic [CW-1:0] r_count_q;
            logic [CW-1:0] w_count_d;
            logic          w_level;

            assign w_level = ACTIVE ? (&r_sync_q) : ~(|r_sync_q);

            // Saturates at LENGTH so hit_o stays asserted while the level persists.
            always_comb begin
                w_count_d = r_count_q;
                if (clear_i || !w_level) begin
                    w_count_d = '0;
                end else if (r_count_q != CW'(LENGTH)) begin
                    w_count_d = r_count_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_count_q <= '0;
                end else begin
                    r_count_q <= w_count_d;
                end
            end

            assign hit_o = (r_count_q == CW'(LENGTH));
        end
    endgenerate

endmodule

// File: rtl/dnpcie_aurora_link_watchdog.sv
// Aurora reset-handshake initiator: watches channel_up/hard_err and retries via ext_reset.
// Define AURORA_WATCHDOG_STATS_EN to enable the link_down_count_o statistics counter.
module dnpcie_aurora_link_watchdog
    import dnpcie_aurora_wd_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 1,
    parameter int unsigned UP_STABLE   = 16,
    parameter int unsigned DOWN_FILTER = 8,
    parameter int unsigned MAX_RETRIES = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 channel_up_i,
    input  logic [NUM_LANES-1:0] lane_up_i,
    input  logic                 hard_err_i,
    input  logic                 reset_busy_i,
    input  logic [31:0]          timeout_i,
    input  logic                 force_reset_i,
    output logic                 reset_req_o,
    output logic                 link_ok_o,
    output logic                 fail_o,
    output logic [RETRY_W-1:0]   retry_count_o,
    output logic [STATE_W-1:0]   state_o,
    output logic [STAT_W-1:0]    link_down_count_o
);

    wd_state_e          r_state_q, w_state_d;
    logic [31:0]        r_timer_q, w_timer_d, w_timer_inc;
    logic [31:0]        r_timeout_q, w_timeout_d;
    logic [RETRY_W-1:0] r_retry_q, w_retry_d;
    logic               r_reset_req_q, r_link_ok_q, r_fail_q;

    logic                 w_up_hit, w_down_hit, w_hard_err_sync;
    logic                 w_unused_up_sync, w_unused_down_sync;
    logic                 w_unused_herr_hit, w_unused_lane_hit;
    logic [NUM_LANES-1:0] w_unused_lane_sync;

    dnpcie_aurora_wd_filter #(.WIDTH(1), .LENGTH(UP_STABLE), .ACTIVE(1'b1)) u_up_filter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (channel_up_i),
        .clear_i (r_state_q != StWaitUp),
        .sync_o  (w_unused_up_sync),
        .hit_o   (w_up_hit)
    );

    dnpcie_aurora_wd_filter #(.WIDTH(1), .LENGTH(DOWN_FILTER), .ACTIVE(1'b0)) u_down_filter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (channel_up_i),
        .clear_i (r_state_q != StUp),
        .sync_o  (w_unused_down_sync),
        .hit_o   (w_down_hit)
    );

    dnpcie_aurora_wd_filter #(.WIDTH(1), .LENGTH(0), .ACTIVE(1'b1)) u_herr_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (hard_err_i),
        .clear_i (1'b0),
        .sync_o  (w_hard_err_sync),
        .hit_o   (w_unused_herr_hit)
    );

    // Lane status is only synchronized; nothing in the FSM depends on it.
    dnpcie_aurora_wd_filter #(.WIDTH(NUM_LANES), .LENGTH(0), .ACTIVE(1'b1)) u_lane_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (lane_up_i),
        .clear_i (1'b0),
        .sync_o  (w_unused_lane_sync),
        .hit_o   (w_unused_lane_hit)
    );

    assign w_timer_inc = r_timer_q + 32'd1;

    always_comb begin
        w_state_d   = r_state_q;
        w_timer_d   = r_timer_q;
        w_timeout_d = r_timeout_q;
        w_retry_d   = r_retry_q;
        case (r_state_q)
            StIdle: begin
                if (!reset_busy_i) begin
                    w_state_d   = StWaitUp;
                    w_timeout_d = timeout_i;
                    w_timer_d   = '0;
                end
            end
            StWaitUp: begin
                w_timer_d = w_timer_inc;
                if (force_reset_i) begin
                    w_state_d = StReq;
                end else if (w_up_hit) begin
                    w_state_d = StUp;
                    w_retry_d = '0;
                end else if ((r_timeout_q != '0) && (w_timer_inc == r_timeout_q)) begin
                    w_state_d = StReq;
                end
            end
            StUp: begin
                if (force_reset_i || w_hard_err_sync || w_down_hit) begin
                    w_state_d = StReq;
                end
            end
            StReq: begin
                if (reset_busy_i) begin
                    w_state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!reset_busy_i) begin
                    if ((MAX_RETRIES != 0) && (32'(r_retry_q) >= MAX_RETRIES)) begin
                        w_state_d = StFailed;
                    end else begin
                        w_state_d   = StWaitUp;
                        w_timeout_d = timeout_i;
                        w_timer_d   = '0;
                    end
                end
            end
            StFailed: begin
                if (force_reset_i) begin
                    w_state_d = StReq;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // A fresh request after FAILED restarts the attempt count at 1.
        if ((w_state_d == StReq) && (r_state_q != StReq)) begin
            w_retry_d = retry_sat_inc((r_state_q == StFailed) ? {RETRY_W{1'b0}} : r_retry_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q     <= StIdle;
            r_timer_q     <= '0;
            r_timeout_q   <= '0;
            r_retry_q     <= '0;
            r_reset_req_q <= 1'b0;
            r_link_ok_q   <= 1'b0;
            r_fail_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_timer_q     <= w_timer_d;
            r_timeout_q   <= w_timeout_d;
            r_retry_q     <= w_retry_d;
            r_reset_req_q <= (w_state_d == StReq);
            r_link_ok_q   <= (w_state_d == StUp);
            r_fail_q      <= (w_state_d == StFailed);
        end
    end

    assign reset_req_o   = r_reset_req_q;
    assign link_ok_o     = r_link_ok_q;
    assign fail_o        = r_fail_q;
    assign retry_count_o = r_retry_q;
    assign state_o       = r_state_q;

`ifdef AURORA_WATCHDOG_STATS_EN
    logic [STAT_W-1:0] r_stat_q;
    logic              r_herr_prev_q;
    logic              w_stat_inc;

    // Hard errors while UP are already counted through the UP->REQ transition.
    assign w_stat_inc = ((r_state_q == StUp) && (w_state_d == StReq)) ||
                        (w_hard_err_sync && !r_herr_prev_q && (r_state_q != StUp));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat_q      <= '0;
            r_herr_prev_q <= 1'b0;
        end else begin
            r_herr_prev_q <= w_hard_err_sync;
            if (w_stat_inc && !(&r_stat_q)) begin
                r_stat_q <= r_stat_q + 1'b1;
            end
        end
    end

    assign link_down_count_o = r_stat_q;
`else
    assign link_down_count_o = '0;
`endif

endmodule
